// File: rtl/mem_dma_pkg.sv
// rtl/mem_dma_pkg.sv - shared types and default widths for the block-copy engine
package mem_dma_pkg;

   localparam int DEF_AW = 8;
   localparam int DEF_DW = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } dma_state_t;

endpackage

// File: rtl/mem_dma.sv
// rtl/mem_dma.sv - byte-at-a-time block copy engine owning the data memory port
module mem_dma
   import mem_dma_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          Start,
   input  logic [AW-1:0] SrcAddr,
   input  logic [AW-1:0] DstAddr,
   input  logic [AW-1:0] Len,
   output logic          Busy,
   output logic          Done,
   input  logic [AW-1:0] CoreAddr,
   input  logic          CoreWrEn,
   input  logic [DW-1:0] CoreDataIn,
   output logic          CoreStall,
   output logic [AW-1:0] MemAddr,
   output logic          MemWrEn,
   output logic [DW-1:0] MemDataIn,
   input  logic [DW-1:0] MemDataOut
);

   localparam logic [AW-1:0] ONE = AW'(1);

   dma_state_t    state_q;
   logic [AW-1:0] src_q;
   logic [AW-1:0] dst_q;
   logic [AW-1:0] rem_q;
   logic [DW-1:0] buf_q;
   logic          busy_q;
   logic          done_q;

   // Copy sequencer: alternates READ/WRITE per byte, with Busy/Done registered alongside the state
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         buf_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (Start) begin
                  src_q <= SrcAddr;
                  dst_q <= DstAddr;
                  rem_q <= Len;
                  if (Len == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= READ;
                     busy_q  <= 1'b1;
                  end
               end
            end
            READ: begin
               buf_q   <= MemDataOut;
               src_q   <= src_q + ONE;
               state_q <= WRITE;
            end
            WRITE: begin
               dst_q <= dst_q + ONE;
               rem_q <= rem_q - ONE;
               if (rem_q == ONE) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= READ;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Memory port mux: core passthrough unless copying; reset blocks any write landing this cycle
   always_comb begin
      MemAddr   = CoreAddr;
      MemWrEn   = CoreWrEn;
      MemDataIn = CoreDataIn;
      case (state_q)
         READ: begin
            MemAddr = src_q;
            MemWrEn = 1'b0;
         end
         WRITE: begin
            MemAddr   = dst_q;
            MemDataIn = buf_q;
            MemWrEn   = 1'b1;
         end
         default: ;
      endcase
      if (Reset) begin
         MemWrEn = 1'b0;
      end
   end

   assign Busy      = busy_q;
   assign Done      = done_q;
   assign CoreStall = busy_q;

endmodule

// File: tb/tb_mem_dma.sv
// tb/tb_mem_dma.sv - directed bench for mem_dma with a 256 x 8 memory model beside it
module tb_mem_dma;
   import mem_dma_pkg::*;

   logic       CLK = 1'b0;
   logic       Reset;
   logic       Start;
   logic [7:0] SrcAddr, DstAddr, Len;
   logic       Busy, Done, CoreStall;
   logic [7:0] CoreAddr, CoreDataIn;
   logic       CoreWrEn;
   logic [7:0] MemAddr, MemDataIn, MemDataOut;
   logic       MemWrEn;

   logic [7:0] mem [256];
   int         wr_count = 0;
   int         passed = 0;
   int         total = 0;

   int         done_cyc, busy_cnt, stall_cnt, wr, both;

   always #5 CLK = ~CLK;

   mem_dma #(.AW(8), .DW(8)) dut (
      .CLK(CLK), .Reset(Reset), .Start(Start),
      .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Len(Len),
      .Busy(Busy), .Done(Done),
      .CoreAddr(CoreAddr), .CoreWrEn(CoreWrEn), .CoreDataIn(CoreDataIn),
      .CoreStall(CoreStall),
      .MemAddr(MemAddr), .MemWrEn(MemWrEn), .MemDataIn(MemDataIn),
      .MemDataOut(MemDataOut)
   );

   assign MemDataOut = mem[MemAddr];

   // Memory model: write on rising edge, and tally every write that lands
   always @(posedge CLK) begin
      if (MemWrEn) begin
         mem[MemAddr] <= MemDataIn;
         wr_count     <= wr_count + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic core_store(input logic [7:0] a, input logic [7:0] d);
      CoreAddr   = a;
      CoreDataIn = d;
      CoreWrEn   = 1'b1;
      @(posedge CLK);
      #1;
      CoreWrEn   = 1'b0;
   endtask

   // Start a copy and observe it cycle by cycle; cycle 1 is the cycle after the Start edge.
   task automatic run_copy(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] n,
                           input bit iso, input int rst_at);
      int w0;
      SrcAddr = src;
      DstAddr = dst;
      Len     = n;
      Start   = 1'b1;
      w0      = wr_count;
      @(posedge CLK);
      #1;
      Start = 1'b0;
      if (iso) begin
         CoreAddr   = 8'h90;
         CoreDataIn = 8'hEE;
         CoreWrEn   = 1'b1;
      end
      done_cyc  = 0;
      busy_cnt  = 0;
      stall_cnt = 0;
      both      = 0;
      for (int cyc = 1; cyc <= 600; cyc++) begin
         if (Busy) busy_cnt++;
         if (CoreStall) stall_cnt++;
         if (Busy && Done) both++;
         if (!Busy) CoreWrEn = 1'b0;
         if (Done && done_cyc == 0) done_cyc = cyc;
         if (rst_at != 0 && cyc == rst_at) begin
            Reset = 1'b1;
            #1;
            check("reset_blocks_write", MemWrEn, 1'b0);
         end
         if (rst_at != 0 && cyc == rst_at + 1) Reset = 1'b0;
         if (rst_at == 0 && done_cyc != 0) break;
         if (rst_at != 0 && cyc == rst_at + 6) break;
         @(posedge CLK);
         #1;
      end
      wr = wr_count - w0;
   endtask

   initial begin
      Reset      = 1'b1;
      Start      = 1'b0;
      SrcAddr    = 8'h00;
      DstAddr    = 8'h00;
      Len        = 8'h00;
      CoreAddr   = 8'h33;
      CoreDataIn = 8'h99;
      CoreWrEn   = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_busy", Busy, 1'b0);
      check("rst_done", Done, 1'b0);
      check("rst_stall", CoreStall, 1'b0);
      check("rst_memwren", MemWrEn, 1'b0);
      check("rst_state", dut.state_q, IDLE);
      Reset    = 1'b0;
      CoreWrEn = 1'b0;

      core_store(8'h10, 8'hA1); core_store(8'h11, 8'hB2);
      core_store(8'h12, 8'hC3); core_store(8'h13, 8'hD4);
      core_store(8'h14, 8'hE5); core_store(8'h15, 8'hF6);
      core_store(8'h16, 8'h07); core_store(8'h17, 8'h18);
      core_store(8'hFE, 8'h11); core_store(8'hFF, 8'h22);
      core_store(8'h00, 8'h33);
      core_store(8'h50, 8'h01); core_store(8'h51, 8'h02);
      core_store(8'h52, 8'h03); core_store(8'h53, 8'h04);
      core_store(8'h90, 8'h55);
      core_store(8'h80, 8'h5A);
      for (int i = 0; i < 8; i++) core_store(8'h60 + 8'(i), 8'hC0 + 8'(i));

      // basic copy with a core store held during it
      run_copy(8'h10, 8'h40, 8'd4, 1'b1, 0);
      check("basic_m40", mem[8'h40], 8'hA1);
      check("basic_m41", mem[8'h41], 8'hB2);
      check("basic_m42", mem[8'h42], 8'hC3);
      check("basic_m43", mem[8'h43], 8'hD4);
      check("basic_done_cyc", done_cyc, 9);
      check("basic_busy_cnt", busy_cnt, 8);
      check("basic_writes", wr, 4);
      check("basic_stall_cnt", stall_cnt, 8);
      check("basic_busy_done", both, 0);
      @(posedge CLK); #1;
      check("iso_m90_kept", mem[8'h90], 8'h55);
      core_store(8'h90, 8'hEE);
      check("iso_m90_after", mem[8'h90], 8'hEE);

      // zero-length copy
      run_copy(8'h00, 8'h80, 8'd0, 1'b0, 0);
      check("len0_done_cyc", done_cyc, 1);
      check("len0_busy_cnt", busy_cnt, 0);
      check("len0_writes", wr, 0);
      check("len0_m80", mem[8'h80], 8'h5A);
      @(posedge CLK); #1;

      // source pointer wraps 0xFF -> 0x00
      run_copy(8'hFE, 8'h20, 8'd3, 1'b0, 0);
      check("wrap_m20", mem[8'h20], 8'h11);
      check("wrap_m21", mem[8'h21], 8'h22);
      check("wrap_m22", mem[8'h22], 8'h33);
      check("wrap_done_cyc", done_cyc, 7);
      check("wrap_writes", wr, 3);
      @(posedge CLK); #1;

      // overlapping forward copy smears the first byte
      run_copy(8'h50, 8'h51, 8'd3, 1'b0, 0);
      check("ovl_m50", mem[8'h50], 8'h01);
      check("ovl_m51", mem[8'h51], 8'h01);
      check("ovl_m52", mem[8'h52], 8'h01);
      check("ovl_m53", mem[8'h53], 8'h01);
      @(posedge CLK); #1;

      // reset during the third WRITE cycle (cycle 6)
      run_copy(8'h10, 8'h60, 8'd8, 1'b0, 6);
      check("rstmid_no_done", done_cyc, 0);
      check("rstmid_writes", wr, 2);
      check("rstmid_state", dut.state_q, IDLE);
      check("rstmid_busy", Busy, 1'b0);
      check("rstmid_m60", mem[8'h60], 8'hA1);
      check("rstmid_m61", mem[8'h61], 8'hB2);
      check("rstmid_m62", mem[8'h62], 8'hC2);
      check("rstmid_m63", mem[8'h63], 8'hC3);

      // fresh copy after the aborted one
      run_copy(8'h10, 8'h70, 8'd2, 1'b0, 0);
      check("after_m70", mem[8'h70], 8'hA1);
      check("after_m71", mem[8'h71], 8'hB2);
      check("after_done_cyc", done_cyc, 5);
      @(posedge CLK); #1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
